score_bcd_accumulator: RTL and testbench

- Upstream neighbour of the four-digit seven-segment display driver.
- Accepts line-clear events from the game control FSM and converts line counts to points.
- Accumulates a saturating 4-digit BCD score and drives the display's four digit inputs directly.
- Uses a serial BCD increment engine (one point per clock), so no binary-to-BCD divider is needed.

---
 rtl/tetris_score_pkg.sv | 22 ++
 rtl/bcd_digit_inc.sv | 24 ++
 rtl/score_bcd_accumulator.sv | 121 ++++++++++++
 tb/tb_score_bcd_accumulator.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_score_pkg.sv
// Shared constants and types for the Tetris score path: BCD digit width,
// digit maximum, default points per line-clear size, and the accumulator states.
package tetris_score_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t DIGIT_MAX = 4'd9;

    localparam logic [3:0] DEF_PTS_1 = 4'd1;
    localparam logic [3:0] DEF_PTS_2 = 4'd3;
    localparam logic [3:0] DEF_PTS_3 = 4'd5;
    localparam logic [3:0] DEF_PTS_4 = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_inc.sv
// Single BCD digit incrementer: adds carry_i to the digit, wrapping 9 -> 0
// and raising carry_o so digits can be chained into a ripple counter.
module bcd_digit_inc
    import tetris_score_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  logic       carry_i,
    output bcd_digit_t digit_o,
    output logic       carry_o
);

    logic at_max;

    assign at_max  = (digit_i == DIGIT_MAX);
    assign carry_o = carry_i & at_max;

    always_comb begin
        digit_o = digit_i;
        if (carry_i) begin
            digit_o = at_max ? '0 : digit_i + 1'b1;
        end
    end

endmodule

// File: rtl/score_bcd_accumulator.sv
// Converts line-clear events into points and adds them one per clock to a
// saturating four-digit BCD score that feeds the seven-segment display driver.
module score_bcd_accumulator
    import tetris_score_pkg::*;
#(
    parameter logic [3:0] PTS_1 = DEF_PTS_1,
    parameter logic [3:0] PTS_2 = DEF_PTS_2,
    parameter logic [3:0] PTS_3 = DEF_PTS_3,
    parameter logic [3:0] PTS_4 = DEF_PTS_4
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_reset,
    input  logic       lines_valid,
    input  logic [2:0] lines_count,
    output logic       lines_ready,
    output logic [3:0] score4,
    output logic [3:0] score3,
    output logic [3:0] score2,
    output logic [3:0] score1,
    output logic       score_done,
    output logic       saturated
);

    state_t            state_q;
    logic [3:0]        remaining_q;
    bcd_digit_t        digit_q [NUM_DIGITS];
    bcd_digit_t        digit_d [NUM_DIGITS];
    logic [NUM_DIGITS:0] carry;
    logic              score_done_q;
    logic              saturated_q;
    logic [3:0]        load_pts;
    logic              all_nines;

    // Ripple chain with a constant carry-in: digit_d is always score + 1.
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_inc u_inc (
                .digit_i (digit_q[gi]),
                .carry_i (carry[gi]),
                .digit_o (digit_d[gi]),
                .carry_o (carry[gi+1])
            );
        end
    endgenerate

    // Carry out of the top digit means every digit is 9.
    assign all_nines = carry[NUM_DIGITS];

    assign lines_ready = (state_q == IDLE) && !game_reset;

    always_comb begin
        load_pts = 4'd0;
        case (lines_count)
            3'd1:    load_pts = PTS_1;
            3'd2:    load_pts = PTS_2;
            3'd3:    load_pts = PTS_3;
            3'd4:    load_pts = PTS_4;
            default: load_pts = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            remaining_q  <= 4'd0;
            score_done_q <= 1'b0;
            saturated_q  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
        end else if (game_reset) begin
            state_q      <= IDLE;
            remaining_q  <= 4'd0;
            score_done_q <= 1'b0;
            saturated_q  <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            score_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Out-of-range counts are consumed silently.
                    if (lines_valid && lines_ready && (load_pts != 4'd0)) begin
                        remaining_q <= load_pts;
                        state_q     <= ADD;
                    end
                end
                ADD: begin
                    if (all_nines) begin
                        saturated_q  <= 1'b1;
                        remaining_q  <= 4'd0;
                        state_q      <= IDLE;
                        score_done_q <= 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            digit_q[i] <= digit_d[i];
                        end
                        remaining_q <= remaining_q - 4'd1;
                        if (remaining_q == 4'd1) begin
                            state_q      <= IDLE;
                            score_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign score1     = digit_q[0];
    assign score2     = digit_q[1];
    assign score3     = digit_q[2];
    assign score4     = digit_q[3];
    assign score_done = score_done_q;
    assign saturated  = saturated_q;

endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Self-checking bench for score_bcd_accumulator: table vectors, hand-written
// corner sequences and random events against an event-level score model.
module tb_score_bcd_accumulator;
    import tetris_score_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_reset = 1'b0;
    logic       lines_valid = 1'b0;
    logic [2:0] lines_count = 3'd0;
    logic       lines_ready;
    logic [3:0] score4, score3, score2, score1;
    logic       score_done;
    logic       saturated;

    int checks = 0;
    int errors = 0;
    int model_score = 0;
    bit model_sat = 1'b0;

    typedef struct {
        int count;
        int exp_score;
        int exp_cycles;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    score_bcd_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .game_reset  (game_reset),
        .lines_valid (lines_valid),
        .lines_count (lines_count),
        .lines_ready (lines_ready),
        .score4      (score4),
        .score3      (score3),
        .score2      (score2),
        .score1      (score1),
        .score_done  (score_done),
        .saturated   (saturated)
    );

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic int pts_of(input int c);
        case (c)
            1:       return int'(DEF_PTS_1);
            2:       return int'(DEF_PTS_2);
            3:       return int'(DEF_PTS_3);
            4:       return int'(DEF_PTS_4);
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_score(input string name, input int exp_score);
        logic [15:0] act;
        act = {score4, score3, score2, score1};
        checks++;
        if (act !== to_bcd(exp_score)) begin
            errors++;
            $display("FAIL %s: score %h expected %h", name, act, to_bcd(exp_score));
        end
    endtask

    // Event-level model: points add until 9999; an increment due at 9999 saturates.
    task automatic model_event(input int c, output int cyc);
        int p;
        p = pts_of(c);
        if (p == 0) begin
            cyc = 0;
        end else if (model_score + p <= 9999) begin
            cyc = p;
            model_score += p;
        end else begin
            cyc = 10000 - model_score;
            model_score = 9999;
            model_sat = 1'b1;
        end
    endtask

    task automatic apply_event(input int c, input bit quiet, output int cyc);
        int exp_cyc;
        int wait_n;
        bit ready_bad;
        model_event(c, exp_cyc);
        cyc = 0;
        ready_bad = 1'b0;
        @(negedge clk);
        lines_valid = 1'b1;
        lines_count = 3'(c);
        wait_n = 0;
        while (lines_ready !== 1'b1 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (wait_n >= 50) begin
            check("accept_timeout", 32'(wait_n), 32'd0);
            lines_valid = 1'b0;
            return;
        end
        @(negedge clk);
        lines_valid = 1'b0;
        if (exp_cyc == 0) begin
            for (int k = 0; k < 3; k++) begin
                if (lines_ready !== 1'b1 || score_done !== 1'b0) ready_bad = 1'b1;
                @(negedge clk);
            end
            check("invalid_no_effect", 32'(ready_bad), 32'd0);
        end else begin
            while (score_done !== 1'b1 && cyc < 40) begin
                if (lines_ready !== 1'b0) ready_bad = 1'b1;
                @(negedge clk);
                cyc++;
            end
            check("busy_cycles", 32'(cyc), 32'(exp_cyc));
            check("ready_low_in_add", 32'(ready_bad), 32'd0);
            check("ready_with_done", 32'(lines_ready), 32'd1);
        end
        check_score("score", model_score);
        check("saturated", 32'(saturated), 32'(model_sat));
        if (exp_cyc != 0) begin
            @(negedge clk);
            check("done_one_pulse", 32'(score_done), 32'd0);
        end
        if (!quiet)
            $display("event count=%0d cycles=%0d score=%0d%0d%0d%0d sat=%0b",
                     c, cyc, score4, score3, score2, score1, saturated);
    endtask

    task automatic preload(input int target);
        int dummy;
        while (target - model_score >= 8) apply_event(4, 1'b1, dummy);
        while (target - model_score >= 5) apply_event(3, 1'b1, dummy);
        while (target - model_score >= 3) apply_event(2, 1'b1, dummy);
        while (target - model_score >= 1) apply_event(1, 1'b1, dummy);
        $display("preload target=%0d score=%0d%0d%0d%0d", target, score4, score3, score2, score1);
    endtask

    task automatic do_game_reset();
        @(negedge clk);
        game_reset = 1'b1;
        #1 check("greset_ready_low", 32'(lines_ready), 32'd0);
        @(negedge clk);
        game_reset = 1'b0;
        model_score = 0;
        model_sat = 1'b0;
        check_score("greset_score", 0);
        check("greset_sat", 32'(saturated), 32'd0);
        $display("game_reset score=%0d%0d%0d%0d sat=%0b", score4, score3, score2, score1, saturated);
    endtask

    task automatic mid_add_abort(input bit use_rst);
        int s0;
        s0 = model_score;
        @(negedge clk);
        lines_valid = 1'b1;
        lines_count = 3'd4;
        check("abort_ready_before", 32'(lines_ready), 32'd1);
        @(negedge clk);
        lines_count = 3'd1;
        @(negedge clk);
        @(negedge clk);
        check_score("abort_mid_score", s0 + 2);
        if (use_rst) rst_n = 1'b0;
        else game_reset = 1'b1;
        #1 check("abort_ready_during", 32'(lines_ready), 32'd0);
        @(negedge clk);
        check_score("abort_cleared", 0);
        check("abort_done", 32'(score_done), 32'd0);
        check("abort_sat", 32'(saturated), 32'd0);
        rst_n = 1'b1;
        game_reset = 1'b0;
        lines_valid = 1'b0;
        #1 check("abort_idle", 32'(lines_ready), 32'd1);
        @(negedge clk);
        check_score("abort_no_accept", 0);
        check("abort_still_idle", 32'(lines_ready), 32'd1);
        check("abort_no_done", 32'(score_done), 32'd0);
        model_score = 0;
        model_sat = 1'b0;
        $display("abort via %s score=%0d%0d%0d%0d", use_rst ? "rst_n" : "game_reset",
                 score4, score3, score2, score1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int s0;

        tbl[0] = '{4, 8, 8};
        tbl[1] = '{3, 13, 5};
        tbl[2] = '{2, 16, 3};
        tbl[3] = '{1, 17, 1};
        tbl[4] = '{0, 17, 0};
        tbl[5] = '{5, 17, 0};
        tbl[6] = '{7, 17, 0};
        tbl[7] = '{4, 25, 8};

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_score("reset_score", 0);
        check("reset_ready", 32'(lines_ready), 32'd1);
        check("reset_done", 32'(score_done), 32'd0);
        check("reset_sat", 32'(saturated), 32'd0);
        $display("reset score=%0d%0d%0d%0d ready=%0b", score4, score3, score2, score1, lines_ready);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            apply_event(tbl[i].count, 1'b0, cyc);
            check("tbl_cycles", 32'(cyc), 32'(tbl[i].exp_cycles));
            check_score("tbl_score", tbl[i].exp_score);
        end

        // Back-to-back single-line events with lines_valid held high
        s0 = model_score;
        @(negedge clk);
        lines_valid = 1'b1;
        lines_count = 3'd1;
        for (int k = 0; k < 6; k++) begin
            check("b2b_ready", 32'(lines_ready), 32'((k % 2) == 0));
            check("b2b_done", 32'(score_done), 32'((k > 0) && ((k % 2) == 0)));
            check_score("b2b_score", s0 + k / 2);
            if (k == 5) lines_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_last_done", 32'(score_done), 32'd1);
        check_score("b2b_final", s0 + 3);
        for (int k = 0; k < 3; k++) model_event(1, cyc);
        $display("back-to-back score=%0d%0d%0d%0d", score4, score3, score2, score1);

        // Carry ripple 0998 + 3
        preload(998);
        @(negedge clk);
        lines_valid = 1'b1;
        lines_count = 3'd2;
        @(negedge clk);
        lines_valid = 1'b0;
        check_score("carry_0", 998);
        @(negedge clk);
        check_score("carry_1", 999);
        @(negedge clk);
        check_score("carry_2", 1000);
        @(negedge clk);
        check_score("carry_3", 1001);
        check("carry_done", 32'(score_done), 32'd1);
        model_event(2, cyc);
        $display("carry score=%0d%0d%0d%0d", score4, score3, score2, score1);
        @(negedge clk);

        // Saturation
        preload(9995);
        apply_event(4, 1'b0, cyc);
        check("sat_cycles", 32'(cyc), 32'd5);
        check_score("sat_score", 9999);
        check("sat_flag", 32'(saturated), 32'd1);
        apply_event(1, 1'b0, cyc);
        check("sat_again_cycles", 32'(cyc), 32'd1);
        apply_event(4, 1'b0, cyc);
        check("sat_again4_cycles", 32'(cyc), 32'd1);
        do_game_reset();

        // Aborts mid-ADD
        apply_event(2, 1'b0, cyc);
        mid_add_abort(1'b0);
        apply_event(3, 1'b0, cyc);
        mid_add_abort(1'b1);

        // Random events
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            apply_event(int'($urandom_range(0, 7)), 1'b0, cyc);
        end
        preload(9960);
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            apply_event(int'($urandom_range(0, 7)), 1'b0, cyc);
        end
        do_game_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
